// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses imem, and registers the
// fetched word into the IF/ID pipeline register with stall/flush/redirect control.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 64,
  parameter logic [31:0] NOP        = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic [31:0] PCF,
  input  logic [31:0] InstrF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        FaultD
);

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);

  logic        fault_f;
  logic [31:0] pc_plus4_f;

  assign pc_plus4_f = PCF + 32'd4;
  // A word index past the end of imem or any nonzero byte offset is a fault.
  assign fault_f    = (PCF[1:0] != 2'b00) || ({2'b00, PCF[31:2]} >= IMEM_LIMIT);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, regardless of the order the blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (reset) begin
      PCF <= RESET_PC;
    end else if (PCSrcE) begin
      PCF <= PCTargetE;
    end else if (!StallF) begin
      PCF <= pc_plus4_f;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || FlushD) begin
      InstrD   <= NOP;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
      FaultD   <= 1'b0;
    end else if (!StallD) begin
      InstrD   <= fault_f ? NOP : InstrF;
      PCD      <= PCF;
      PCPlus4D <= pc_plus4_f;
      ValidD   <= 1'b1;
      FaultD   <= fault_f;
    end
  end

endmodule
